// File: rtl/add_serial.sv
// add_serial: rebuilds a full Y_WIDTH-bit $add result from a narrow SLICE_WIDTH adder,
// one slice per clock, with the carry rippled between slices through a register.
module add_serial #(
   parameter int A_SIGNED    = 0,
   parameter int B_SIGNED    = 0,
   parameter int A_WIDTH     = 8,
   parameter int B_WIDTH     = 8,
   parameter int Y_WIDTH     = 16,
   parameter int SLICE_WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] A,
   input  logic [B_WIDTH-1:0] B,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [Y_WIDTH-1:0] Y,
   output logic               busy
);

   localparam int N  = (Y_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 r_state;
   state_t                 w_nextState;
   logic [Y_WIDTH-1:0]     r_a;
   logic [Y_WIDTH-1:0]     r_b;
   logic [Y_WIDTH-1:0]     r_y;
   logic [KW-1:0]          r_k;
   logic                   r_carry;
   logic [Y_WIDTH-1:0]     w_aExt;
   logic [Y_WIDTH-1:0]     w_bExt;
   logic [Y_WIDTH-1:0]     w_yNext;
   logic [31:0]            w_shift;
   logic [SLICE_WIDTH-1:0] w_aSlice;
   logic [SLICE_WIDTH-1:0] w_bSlice;
   logic [SLICE_WIDTH:0]   w_sum;

   // Signed extension only when both operands are signed; otherwise both zero-extend.
   generate
      if (A_SIGNED != 0 && B_SIGNED != 0) begin : g_signed
         assign w_aExt = Y_WIDTH'({{Y_WIDTH{A[A_WIDTH-1]}}, A});
         assign w_bExt = Y_WIDTH'({{Y_WIDTH{B[B_WIDTH-1]}}, B});
      end else begin : g_unsigned
         assign w_aExt = Y_WIDTH'({{Y_WIDTH{1'b0}}, A});
         assign w_bExt = Y_WIDTH'({{Y_WIDTH{1'b0}}, B});
      end
   endgenerate

   // Bits above Y_WIDTH in the last slice shift in as zero and fall off when written back.
   assign w_shift  = 32'(r_k) * 32'(SLICE_WIDTH);
   assign w_aSlice = SLICE_WIDTH'(r_a >> w_shift);
   assign w_bSlice = SLICE_WIDTH'(r_b >> w_shift);
   assign w_sum    = (SLICE_WIDTH+1)'(w_aSlice) + (SLICE_WIDTH+1)'(w_bSlice)
                   + (SLICE_WIDTH+1)'(r_carry);
   assign w_yNext  = r_y | (Y_WIDTH'(w_sum[SLICE_WIDTH-1:0]) << w_shift);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid)      w_nextState = CALC;
         CALC:    if (r_k == LAST_K) w_nextState = DONE;
         DONE:    if (out_ready)     w_nextState = IDLE;
         default:                    w_nextState = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = reset_n && (r_state == IDLE);
      busy      = (r_state == CALC);
      out_valid = (r_state == DONE);
   end

   // Y is cleared on accept so a partially built sum never looks like a result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_y     <= '0;
         r_k     <= '0;
         r_carry <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= w_aExt;
                  r_b     <= w_bExt;
                  r_y     <= '0;
                  r_k     <= '0;
                  r_carry <= 1'b0;
               end
            end
            CALC: begin
               r_y     <= w_yNext;
               r_carry <= w_sum[SLICE_WIDTH];
               r_k     <= r_k + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign Y = r_y;

endmodule

// File: tb/tb_add_serial.sv
// tb_add_serial: drives six add_serial configurations from shared operands and checks
// every result against an arithmetic reference, plus handshake/reset corner sequences.
module tb_add_serial;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
   logic [7:0]  opA = 8'h00;
   logic [7:0]  opB = 8'h00;
   logic [5:0]  inReady;
   logic [5:0]  outValid;
   logic [5:0]  busy;
   logic [15:0] y0, y1, y2, y5;
   logic [9:0]  y3;
   logic [5:0]  y4;

   int checks = 0;
   int failures = 0;

   // Per-instance configuration used by the reference model.
   int cfgAS [6] = '{0, 1, 1, 0, 0, 0};
   int cfgBS [6] = '{0, 1, 0, 0, 0, 0};
   int cfgYW [6] = '{16, 16, 16, 10, 6, 16};

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] e0, e1, e2, e3, e4, e5;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   add_serial #(.A_SIGNED(0), .B_SIGNED(0), .Y_WIDTH(16), .SLICE_WIDTH(4)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[0]), .A(opA), .B(opB),
      .out_valid(outValid[0]), .out_ready(outReady), .Y(y0), .busy(busy[0]));
   add_serial #(.A_SIGNED(1), .B_SIGNED(1), .Y_WIDTH(16), .SLICE_WIDTH(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[1]), .A(opA), .B(opB),
      .out_valid(outValid[1]), .out_ready(outReady), .Y(y1), .busy(busy[1]));
   add_serial #(.A_SIGNED(1), .B_SIGNED(0), .Y_WIDTH(16), .SLICE_WIDTH(4)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[2]), .A(opA), .B(opB),
      .out_valid(outValid[2]), .out_ready(outReady), .Y(y2), .busy(busy[2]));
   add_serial #(.A_SIGNED(0), .B_SIGNED(0), .Y_WIDTH(10), .SLICE_WIDTH(4)) dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[3]), .A(opA), .B(opB),
      .out_valid(outValid[3]), .out_ready(outReady), .Y(y3), .busy(busy[3]));
   add_serial #(.A_SIGNED(0), .B_SIGNED(0), .Y_WIDTH(6), .SLICE_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[4]), .A(opA), .B(opB),
      .out_valid(outValid[4]), .out_ready(outReady), .Y(y4), .busy(busy[4]));
   add_serial #(.A_SIGNED(0), .B_SIGNED(0), .Y_WIDTH(16), .SLICE_WIDTH(16)) dut5 (
      .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReady[5]), .A(opA), .B(opB),
      .out_valid(outValid[5]), .out_ready(outReady), .Y(y5), .busy(busy[5]));

   // Reference: operands as integers, plain addition, then mod 2^Y_WIDTH.
   function automatic logic [15:0] refSum(logic [7:0] a, logic [7:0] b, int idx);
      bit     signedMode;
      longint av, bv, s;
      signedMode = (cfgAS[idx] != 0) && (cfgBS[idx] != 0);
      av = longint'(a);
      bv = longint'(b);
      if (signedMode && a[7]) av = av - 256;
      if (signedMode && b[7]) bv = bv - 256;
      s = (av + bv) & ((longint'(1) << cfgYW[idx]) - 1);
      return s[15:0];
   endfunction

   function automatic logic [15:0] getY(int idx);
      case (idx)
         0:       return y0;
         1:       return y1;
         2:       return y2;
         3:       return {6'b0, y3};
         4:       return {10'b0, y4};
         default: return y5;
      endcase
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One transaction with out_ready held low; returns once every instance shows out_valid.
   task automatic applyStimulus(logic [7:0] a, logic [7:0] b);
      int cnt;
      @(negedge clk);
      opA = a;
      opB = b;
      outReady = 1'b0;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      cnt = 0;
      while (outValid != 6'h3F && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("allValid", 32'(outValid), 32'h3F);
   endtask

   task automatic releaseResult();
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int busyCnt, validCnt, readyIdx;
      logic [15:0] validY;
      logic [7:0] ra, rb;
      bit sawValid;

      vecs[0] = '{8'hFF, 8'h01, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 16'h0100};
      vecs[1] = '{8'h80, 8'hFF, 16'h017F, 16'hFF7F, 16'h017F, 16'h017F, 16'h003F, 16'h017F};
      vecs[2] = '{8'hFF, 8'hFF, 16'h01FE, 16'hFFFE, 16'h01FE, 16'h01FE, 16'h003E, 16'h01FE};
      vecs[3] = '{8'h12, 8'h34, 16'h0046, 16'h0046, 16'h0046, 16'h0046, 16'h0006, 16'h0046};
      vecs[4] = '{8'h7F, 8'h7F, 16'h00FE, 16'h00FE, 16'h00FE, 16'h00FE, 16'h003E, 16'h00FE};
      vecs[5] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      // Reset state, including in_ready forced low while reset is asserted.
      repeat (3) @(negedge clk);
      checkOutput("rstY", 32'(y0), 32'h0);
      checkOutput("rstOutValid", 32'(outValid), 32'h0);
      checkOutput("rstBusy", 32'(busy), 32'h0);
      checkOutput("rstInReady", 32'(inReady), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("relInReady", 32'(inReady), 32'h3F);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d_u16", i), 32'(y0), 32'(vecs[i].e0));
         checkOutput($sformatf("vec%0d_s16", i), 32'(y1), 32'(vecs[i].e1));
         checkOutput($sformatf("vec%0d_as16", i), 32'(y2), 32'(vecs[i].e2));
         checkOutput($sformatf("vec%0d_u10", i), 32'(y3), 32'(vecs[i].e3));
         checkOutput($sformatf("vec%0d_u6", i), 32'(y4), 32'(vecs[i].e4));
         checkOutput($sformatf("vec%0d_n1", i), 32'(y5), 32'(vecs[i].e5));
         releaseResult();
      end

      for (int n = 0; n < 24; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         applyStimulus(ra, rb);
         for (int i = 0; i < 6; i++)
            checkOutput($sformatf("rnd%0d_dut%0d", n, i), 32'(getY(i)), 32'(refSum(ra, rb, i)));
         releaseResult();
      end

      // Latency with out_ready held high: 4 busy cycles, 1 valid cycle, then in_ready.
      @(negedge clk);
      opA = 8'hFF;
      opB = 8'h01;
      outReady = 1'b1;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      busyCnt = 0;
      validCnt = 0;
      readyIdx = -1;
      validY = 16'h0;
      for (int c = 0; c < 10; c++) begin
         if (busy[0]) busyCnt++;
         if (outValid[0]) begin
            validCnt++;
            validY = y0;
         end
         if (inReady[0] && readyIdx < 0) readyIdx = c;
         if (c > 0) @(negedge clk);
         if (c == 0) @(negedge clk);
      end
      outReady = 1'b0;
      checkOutput("latBusyCycles", 32'(busyCnt), 32'd4);
      checkOutput("latValidCycles", 32'(validCnt), 32'd1);
      checkOutput("latY", 32'(validY), 32'h0100);
      checkOutput("latInReadyCycle", 32'(readyIdx), 32'd5);

      // Backpressure in DONE while new operands are offered.
      applyStimulus(8'h12, 8'h34);
      for (int c = 0; c < 5; c++) begin
         opA = 8'hAA;
         opB = 8'h55;
         inValid = 1'b1;
         @(negedge clk);
         checkOutput($sformatf("bpY%0d", c), 32'(y0), 32'h0046);
         checkOutput($sformatf("bpInReady%0d", c), 32'(inReady[0]), 32'h0);
         checkOutput($sformatf("bpOutValid%0d", c), 32'(outValid[0]), 32'h1);
      end
      inValid = 1'b0;
      releaseResult();
      checkOutput("bpRelInReady", 32'(inReady[0]), 32'h1);
      checkOutput("bpRelOutValid", 32'(outValid[0]), 32'h0);
      @(negedge clk);
      checkOutput("bpNoSecondAccept", 32'(busy[0]), 32'h0);

      // Reset during CALC slice 2 (and mid-DONE for the single-slice instance).
      @(negedge clk);
      opA = 8'hFF;
      opB = 8'h01;
      inValid = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midRstOutValid", 32'(outValid), 32'h0);
      checkOutput("midRstY", 32'(y0), 32'h0);
      checkOutput("midRstYn1", 32'(y5), 32'h0);
      checkOutput("midRstBusy", 32'(busy), 32'h0);
      checkOutput("midRstInReady", 32'(inReady[0]), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("postRstInReady", 32'(inReady[0]), 32'h1);
      sawValid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (outValid != 6'h0) sawValid = 1'b1;
         @(negedge clk);
      end
      checkOutput("postRstNoPulse", 32'(sawValid), 32'h0);
      applyStimulus(8'h12, 8'h34);
      checkOutput("postRstSum", 32'(y0), 32'h0046);
      releaseResult();

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
